// File: rtl/interrupt_cp0.sv
// CP0 interrupt responder: Status/Cause/EPC registers, combinational take
// decision and EXL-based NORMAL/HANDLER state for level-sensitive sources.
module interrupt_cp0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
  parameter int unsigned NUM_IRQ      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt_source,
  input  logic [4:0]         regnum,
  input  logic [31:0]        wr_data,
  input  logic               MTC0,
  input  logic               ERET,
  input  logic               stall,
  input  logic [31:0]        next_pc,
  output logic [31:0]        rd_data,
  output logic               TakenInterrupt,
  output logic [31:0]        EPC,
  output logic [31:0]        handler_pc
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} cp0State_e;

  cp0State_e           state;
  logic                ie;
  logic [NUM_IRQ-1:0]  im;
  logic                exl;
  logic [31:0]         statusVal;
  logic [31:0]         causeVal;

  assign exl        = (state == HANDLER);
  assign handler_pc = HANDLER_ADDR;
  assign statusVal  = (32'(im) << 8) | {30'h0, exl, ie};
  assign causeVal   = 32'(interrupt_source) << 8;

  assign TakenInterrupt = (|(interrupt_source & im)) && ie && !exl && !stall && !reset;

  // A take flushes the in-flight instruction, so its MTC0 is dropped here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= NORMAL;
      ie    <= 1'b0;
      im    <= '0;
      EPC   <= 32'h0;
    end else if (!stall) begin
      if (TakenInterrupt) begin
        state <= HANDLER;
        EPC   <= next_pc;
      end else begin
        if (ERET && exl) begin
          state <= NORMAL;
        end
        if (MTC0 && regnum == REG_STATUS) begin
          im    <= wr_data[8 +: NUM_IRQ];
          ie    <= wr_data[0];
          state <= wr_data[1] ? HANDLER : NORMAL;
        end
        if (MTC0 && regnum == REG_EPC) begin
          EPC <= wr_data;
        end
      end
    end
  end

  // MFC0 read mux; writes become visible the cycle after MTC0.
  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = statusVal;
      REG_CAUSE:  rd_data = causeVal;
      REG_EPC:    rd_data = EPC;
      default:    rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_cp0.sv
// Scoreboard bench for interrupt_cp0: expectations are queued as each cycle's
// stimulus is driven and drained against the DUT before the next clock edge.
module tb_interrupt_cp0;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  interrupt_source;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        MTC0;
  logic        ERET;
  logic        stall;
  logic [31:0] next_pc;
  logic [31:0] rd_data;
  logic        TakenInterrupt;
  logic [31:0] EPC;
  logic [31:0] handler_pc;

  interrupt_cp0 dut (
    .clock           (clock),
    .reset           (reset),
    .interrupt_source(interrupt_source),
    .regnum          (regnum),
    .wr_data         (wr_data),
    .MTC0            (MTC0),
    .ERET            (ERET),
    .stall           (stall),
    .next_pc         (next_pc),
    .rd_data         (rd_data),
    .TakenInterrupt  (TakenInterrupt),
    .EPC             (EPC),
    .handler_pc      (handler_pc)
  );

  always #5 clock = ~clock;

  typedef enum int {K_TAKE, K_RD, K_EPC, K_HPC} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int      checks = 0;
  int      passes = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic r, input logic [7:0] src, input logic [4:0] rn,
                       input logic [31:0] wd, input logic mt, input logic er,
                       input logic st, input logic [31:0] npc);
    reset = r; interrupt_source = src; regnum = rn; wr_data = wd;
    MTC0 = mt; ERET = er; stall = st; next_pc = npc;
  endtask

  task automatic expectVal(input string tag, input kind_e kind, input logic [31:0] v);
    sbItem_t it;
    it.tag = tag; it.kind = kind; it.exp = v;
    sbQ.push_back(it);
  endtask

  // Sample mid-cycle, drain the scoreboard, then step to just after the next edge.
  task automatic settle();
    sbItem_t it;
    logic [31:0] obs;
    #4;
    while (sbQ.size() > 0) begin
      it = sbQ.pop_front();
      case (it.kind)
        K_TAKE:  obs = 32'(TakenInterrupt);
        K_RD:    obs = rd_data;
        K_EPC:   obs = EPC;
        default: obs = handler_pc;
      endcase
      checkVal(it.tag, obs, it.exp);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    expectVal("rst_take", K_TAKE, 32'd0); expectVal("rst_status", K_RD, 32'h0);
    expectVal("handler_pc", K_HPC, 32'h80000180); settle();
    drive(1'b1, 8'h80, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("rst_cause", K_RD, 32'h00008000); expectVal("rst_take2", K_TAKE, 32'd0); settle();
    drive(1'b1, 8'h80, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("rst_epc", K_RD, 32'h0); expectVal("rst_epc_port", K_EPC, 32'h0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("post_rst_take", K_TAKE, 32'd0); expectVal("post_rst_status", K_RD, 32'h0); settle();

    // Timer take
    drive(1'b0, 8'h00, 5'd12, 32'h00008001, 1'b1, 1'b0, 1'b0, 32'h0);
    expectVal("wr_status_take", K_TAKE, 32'd0); expectVal("no_fwd_status", K_RD, 32'h0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400024);
    expectVal("timer_take", K_TAKE, 32'd1); expectVal("status_pre_take", K_RD, 32'h00008001); settle();
    expectVal("exl_no_take", K_TAKE, 32'd0); expectVal("status_exl", K_RD, 32'h00008003); settle();
    drive(1'b0, 8'h80, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400028);
    expectVal("epc_rd", K_RD, 32'h00400024); expectVal("epc_port", K_EPC, 32'h00400024); settle();

    // ERET with source still asserted retakes immediately
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00400100);
    expectVal("eret_cycle_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400100);
    expectVal("retake", K_TAKE, 32'd1); expectVal("status_after_eret", K_RD, 32'h00008001); settle();
    drive(1'b0, 8'h80, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("retake_epc", K_RD, 32'h00400100); settle();

    // Source dropped before ERET: no retake
    drive(1'b0, 8'h00, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expectVal("eret2_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h00, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("no_retake", K_TAKE, 32'd0); expectVal("status_normal", K_RD, 32'h00008001); settle();

    // Masking
    drive(1'b0, 8'h00, 5'd12, 32'h00000401, 1'b1, 1'b0, 1'b0, 32'h0);
    expectVal("wr_mask_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd13, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("masked_no_take", K_TAKE, 32'd0); expectVal("cause_masked", K_RD, 32'h00008000); settle();
    drive(1'b0, 8'h04, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400200);
    expectVal("unmasked_take", K_TAKE, 32'd1); expectVal("status_mask", K_RD, 32'h00000401); settle();
    expectVal("mask_exl", K_RD, 32'h00000403); settle();

    // Take plus same-cycle MTC0 to EPC: take wins
    drive(1'b0, 8'h00, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expectVal("eret3_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h04, 5'd14, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h00400300);
    expectVal("take_vs_mtc0", K_TAKE, 32'd1); expectVal("epc_old", K_RD, 32'h00400200); settle();
    drive(1'b0, 8'h04, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("epc_take_wins", K_RD, 32'h00400300); settle();

    // Stall blocks take and MTC0
    drive(1'b0, 8'h00, 5'd12, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    drive(1'b0, 8'h04, 5'd12, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00400400);
    expectVal("stall_no_take", K_TAKE, 32'd0); expectVal("stall_status", K_RD, 32'h00000401); settle();
    drive(1'b0, 8'h04, 5'd12, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00400400);
    expectVal("stall_mtc0_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h00, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("stall_held_status", K_RD, 32'h00000401); settle();
    drive(1'b0, 8'h00, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("stall_held_epc", K_RD, 32'h00400300); settle();

    // Reset mid-handler
    drive(1'b0, 8'h00, 5'd14, 32'h00001234, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    drive(1'b0, 8'h00, 5'd12, 32'h00008003, 1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("mtc0_exl_status", K_RD, 32'h00008003); expectVal("mtc0_exl_no_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("mtc0_epc", K_RD, 32'h00001234); settle();
    drive(1'b1, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("reset_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400500);
    expectVal("mid_rst_status", K_RD, 32'h0); expectVal("mid_rst_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("mid_rst_epc", K_RD, 32'h0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h00008001, 1'b1, 1'b0, 1'b0, 32'h00400500);
    expectVal("ie_rewrite_take", K_TAKE, 32'd0); settle();
    drive(1'b0, 8'h80, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00400600);
    expectVal("take_after_ie", K_TAKE, 32'd1); settle();
    drive(1'b0, 8'h00, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("final_epc", K_RD, 32'h00400600); settle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
